// File: rtl/param_cache_arb_pkg.sv
// param_cache_arb_pkg: shared types for the I/D-cache physical-memory arbiter.
//   arb_state_t : arbiter FSM states
//   req_id_t    : requester identity (I-cache or D-cache)
package param_cache_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D,
      DONE
   } arb_state_t;

   typedef enum logic {
      REQ_I,
      REQ_D
   } req_id_t;

endpackage

// File: rtl/param_cache_arbiter_if.sv
// param_cache_arbiter_if: bundle of the I-cache, D-cache and pmem line ports.
//   slave  : arbiter view (cache requests and memory replies in; grants and responses out)
//   master : environment view (caches plus memory adapter), the mirror of slave
// Parameters: LineW line width in bits, AddrW physical address width.
interface param_cache_arbiter_if #(
   parameter int unsigned LineW = 256,
   parameter int unsigned AddrW = 32
);

   logic             i_read;
   logic [AddrW-1:0] i_addr;
   logic [LineW-1:0] i_rdata;
   logic             i_resp;

   logic             d_read;
   logic             d_write;
   logic [AddrW-1:0] d_addr;
   logic [LineW-1:0] d_wdata;
   logic [LineW-1:0] d_rdata;
   logic             d_resp;

   logic             pmem_read;
   logic             pmem_write;
   logic [AddrW-1:0] pmem_addr;
   logic [LineW-1:0] pmem_wdata;
   logic [LineW-1:0] pmem_rdata;
   logic             pmem_resp;

   modport slave (
      input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
      output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
   );

   modport master (
      output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
   );

endinterface

// File: rtl/param_cache_arb_pick.sv
// param_cache_arb_pick: combinational grant selection for the cache arbiter.
//   i_req_i       : I-cache is requesting
//   d_req_i       : D-cache is requesting (read or writeback)
//   last_grant_i  : requester served by the most recent completed transfer
//   grant_valid_o : some requester is asking
//   grant_id_o    : requester to grant
// Build option ARB_ROUND_ROBIN_EN: on a tie grant the requester not served last;
// otherwise D always wins ties.
module param_cache_arb_pick
   import param_cache_arb_pkg::*;
(
   input  logic    i_req_i,
   input  logic    d_req_i,
   input  req_id_t last_grant_i,
   output logic    grant_valid_o,
   output req_id_t grant_id_o
);

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      grant_valid_o = i_req_i | d_req_i;
      if (i_req_i && d_req_i) begin
         grant_id_o = (last_grant_i == REQ_D) ? REQ_I : REQ_D;
      end else begin
         grant_id_o = d_req_i ? REQ_D : REQ_I;
      end
   end
`else
   // Fixed priority ignores history.
   logic unused_last_grant;
   assign unused_last_grant = (last_grant_i == REQ_D);

   always_comb begin
      grant_valid_o = i_req_i | d_req_i;
      grant_id_o    = d_req_i ? REQ_D : REQ_I;
   end
`endif

endmodule

// File: rtl/param_cache_arbiter.sv
// param_cache_arbiter: shares one pmem line port between the I-cache and D-cache.
// One requester is served at a time; the grant is held until pmem_resp, the response is
// forwarded in the same cycle, then one DONE cycle lets the served cache drop its request.
//   clk, rst : clock, synchronous active-high reset
//   bus      : param_cache_arbiter_if.slave (I/D request ports and pmem port)
// Build option ARB_ROUND_ROBIN_EN (in param_cache_arb_pick): alternate grants on ties.
module param_cache_arbiter
   import param_cache_arb_pkg::*;
#(
   parameter int unsigned LineW = 256,
   parameter int unsigned AddrW = 32
) (
   input logic                  clk,
   input logic                  rst,
   param_cache_arbiter_if.slave bus
);

   arb_state_t state_q, state_d;
   req_id_t    last_grant_q, last_grant_d;

   logic       i_req, d_req;
   logic       grant_valid;
   req_id_t    grant_id;

   logic             read_sel, write_sel;
   logic [AddrW-1:0] addr_sel;
   logic [LineW-1:0] wdata_sel;
   logic             i_resp_sel, d_resp_sel;

   assign i_req = bus.i_read;
   assign d_req = bus.d_read | bus.d_write;

   param_cache_arb_pick u_pick (
      .i_req_i       (i_req),
      .d_req_i       (d_req),
      .last_grant_i  (last_grant_q),
      .grant_valid_o (grant_valid),
      .grant_id_o    (grant_id)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= REQ_I;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   // A dropped request aborts the transfer and takes precedence over pmem_resp.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      unique case (state_q)
         IDLE: begin
            if (grant_valid) begin
               state_d = (grant_id == REQ_D) ? SERVE_D : SERVE_I;
            end
         end
         SERVE_I: begin
            if (!i_req) begin
               state_d = IDLE;
            end else if (bus.pmem_resp) begin
               state_d      = DONE;
               last_grant_d = REQ_I;
            end
         end
         SERVE_D: begin
            if (!d_req) begin
               state_d = IDLE;
            end else if (bus.pmem_resp) begin
               state_d      = DONE;
               last_grant_d = REQ_D;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobes follow the granted requester's live inputs; a D read+write counts as a write.
   always_comb begin
      read_sel   = 1'b0;
      write_sel  = 1'b0;
      addr_sel   = '0;
      wdata_sel  = '0;
      i_resp_sel = 1'b0;
      d_resp_sel = 1'b0;
      unique case (state_q)
         SERVE_I: begin
            read_sel   = bus.i_read;
            addr_sel   = bus.i_addr;
            i_resp_sel = bus.pmem_resp & i_req;
         end
         SERVE_D: begin
            write_sel  = bus.d_write;
            read_sel   = bus.d_read & ~bus.d_write;
            addr_sel   = bus.d_addr;
            d_resp_sel = bus.pmem_resp & d_req;
            if (bus.d_write) begin
               wdata_sel = bus.d_wdata;
            end
         end
         default: ;
      endcase
   end

   assign bus.pmem_read  = read_sel;
   assign bus.pmem_write = write_sel;
   assign bus.pmem_addr  = addr_sel;
   assign bus.pmem_wdata = wdata_sel;
   assign bus.i_resp     = i_resp_sel;
   assign bus.d_resp     = d_resp_sel;

   // Read data is a pure pass-through; only the resp pulse qualifies it.
   assign bus.i_rdata = bus.pmem_rdata;
   assign bus.d_rdata = bus.pmem_rdata;

endmodule
